// File: rtl/host_byte_deframer.sv
// Byte-stream deframer: hunts for SYNC_BYTE, decodes a 12-byte header and
// 32-bit payload words, and hands each word to a downstream master.
module host_byte_deframer #(
    parameter logic [7:0]  SYNC_BYTE = 8'hCD,
    parameter logic [15:0] TIMEOUT   = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    input  logic        i_master_ready,
    output logic        o_ready,
    output logic [31:0] o_command,
    output logic [31:0] o_address,
    output logic [31:0] o_data,
    output logic [27:0] o_data_count,
    output logic        o_frame_error,
    output logic [1:0]  o_state
);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_HEADER      = 2'd1;
    localparam logic [1:0] S_WORD        = 2'd2;
    localparam logic [1:0] S_WAIT_MASTER = 2'd3;

    // Handshake: a byte transfers on a rising edge where i_byte_valid and
    // o_byte_ready are both high; o_ready is a one-cycle strobe with no back-pressure.
    logic [1:0]  state;
    logic        run;
    logic [3:0]  byte_cnt;
    logic [15:0] tmo_cnt;
    logic [87:0] hdr_sr;
    logic [31:0] word_sr;
    logic [27:0] words_left;
    logic [95:0] hdr_next;
    logic        byte_acc;
    logic        tmo_hit;

    // run holds o_byte_ready low until the first edge after reset release.
    assign o_byte_ready = run && (state != S_WAIT_MASTER);
    assign byte_acc     = i_byte_valid && o_byte_ready;
    assign hdr_next     = {hdr_sr, i_byte};
    assign tmo_hit      = (tmo_cnt == TIMEOUT - 16'd1);
    assign o_state      = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            run           <= 1'b0;
            byte_cnt      <= 4'd0;
            tmo_cnt       <= 16'd0;
            hdr_sr        <= 88'd0;
            word_sr       <= 32'd0;
            words_left    <= 28'd0;
            o_ready       <= 1'b0;
            o_frame_error <= 1'b0;
            o_command     <= 32'd0;
            o_address     <= 32'd0;
            o_data        <= 32'd0;
            o_data_count  <= 28'd0;
        end else begin
            run           <= 1'b1;
            o_ready       <= 1'b0;
            o_frame_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (byte_acc && i_byte == SYNC_BYTE) begin
                        state    <= S_HEADER;
                        byte_cnt <= 4'd0;
                        tmo_cnt  <= 16'd0;
                    end
                end
                S_HEADER: begin
                    if (byte_acc) begin
                        hdr_sr  <= {hdr_sr[79:0], i_byte};
                        tmo_cnt <= 16'd0;
                        if (byte_cnt == 4'd11) begin
                            o_data_count <= hdr_next[91:64];
                            o_command    <= hdr_next[63:32];
                            o_address    <= hdr_next[31:0];
                            byte_cnt     <= 4'd0;
                            word_sr      <= 32'd0;
                            // A read still produces one strobe carrying zero data.
                            if (hdr_next[32]) begin
                                state      <= S_WORD;
                                words_left <= (hdr_next[91:64] == 28'd0) ? 28'd1 : hdr_next[91:64];
                            end else begin
                                state      <= S_WAIT_MASTER;
                                words_left <= 28'd1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end else if (tmo_hit) begin
                        state         <= S_IDLE;
                        o_frame_error <= 1'b1;
                        tmo_cnt       <= 16'd0;
                        byte_cnt      <= 4'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_WORD: begin
                    if (byte_acc) begin
                        word_sr <= {word_sr[23:0], i_byte};
                        tmo_cnt <= 16'd0;
                        if (byte_cnt == 4'd3) begin
                            state    <= S_WAIT_MASTER;
                            byte_cnt <= 4'd0;
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end else if (tmo_hit) begin
                        state         <= S_IDLE;
                        o_frame_error <= 1'b1;
                        tmo_cnt       <= 16'd0;
                        byte_cnt      <= 4'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_WAIT_MASTER: begin
                    if (i_master_ready) begin
                        o_ready    <= 1'b1;
                        o_data     <= word_sr;
                        words_left <= words_left - 28'd1;
                        byte_cnt   <= 4'd0;
                        tmo_cnt    <= 16'd0;
                        state      <= (words_left == 28'd1) ? S_IDLE : S_WORD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
